// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared register map, CTRL layout and decode helpers for multi_timer
package timer_pkg;

    localparam logic [7:0] CTRL_OFS    = 8'h00;
    localparam logic [7:0] CNT_OFS     = 8'h04;
    localparam logic [7:0] CMP_OFS     = 8'h08;
    localparam logic [7:0] PSC_OFS     = 8'h0C;
    localparam logic [7:0] STATUS_ADDR = 8'h80;
    localparam logic [7:0] CH_STRIDE   = 8'h10;

    localparam logic [1:0] SEL_CTRL = CTRL_OFS[3:2];
    localparam logic [1:0] SEL_CNT  = CNT_OFS[3:2];
    localparam logic [1:0] SEL_CMP  = CMP_OFS[3:2];
    localparam logic [1:0] SEL_PSC  = PSC_OFS[3:2];

    localparam int EN_BIT      = 0;
    localparam int IE_BIT      = 1;
    localparam int ONESHOT_BIT = 2;
    localparam int CLR_BIT     = 3;

    typedef struct packed {
        logic oneshot;
        logic ie;
        logic en;
    } ctrl_t;

    function automatic logic [2:0] ch_index(input logic [7:0] addr);
        return 3'(addr / CH_STRIDE);
    endfunction

    function automatic logic [1:0] reg_index(input logic [7:0] addr);
        return addr[3:2];
    endfunction

endpackage

// File: rtl/timer_channel.sv
// rtl/timer_channel.sv - one timer channel: CTRL/CNT/CMP/PSC registers, prescaler, counter, match event
module timer_channel
    import timer_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int PSC_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [1:0]       reg_sel,
    input  logic [31:0]      wr_data,
    output ctrl_t            ctrl,
    output logic [CNT_W-1:0] cnt,
    output logic [CNT_W-1:0] cmp,
    output logic [PSC_W-1:0] psc,
    output logic             match
);

    logic [PSC_W-1:0] psc_cnt;
    logic             ctrl_wr;
    logic             cnt_wr;
    logic             cmp_wr;
    logic             psc_wr;
    logic             clr;
    logic             tick;
    logic             at_cmp;

    assign ctrl_wr = wr_en && (reg_sel == SEL_CTRL);
    assign cnt_wr  = wr_en && (reg_sel == SEL_CNT);
    assign cmp_wr  = wr_en && (reg_sel == SEL_CMP);
    assign psc_wr  = wr_en && (reg_sel == SEL_PSC);
    assign clr     = ctrl_wr && wr_data[CLR_BIT];

    assign tick   = ctrl.en && (psc_cnt == psc);
    assign at_cmp = (cnt == cmp);
    // A software load of the counter (CNT write or CLR) overrides a tick in the same cycle.
    assign match  = tick && at_cmp && !cnt_wr && !clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl    <= '0;
            cnt     <= '0;
            cmp     <= '0;
            psc     <= '0;
            psc_cnt <= '0;
        end else begin
            if (cmp_wr) begin
                cmp <= wr_data[CNT_W-1:0];
            end
            if (psc_wr) begin
                psc <= wr_data[PSC_W-1:0];
            end

            if (cnt_wr) begin
                cnt     <= wr_data[CNT_W-1:0];
                psc_cnt <= '0;
            end else if (clr) begin
                cnt     <= '0;
                psc_cnt <= '0;
            end else if (ctrl.en) begin
                if (tick) begin
                    psc_cnt <= '0;
                    cnt     <= at_cmp ? '0 : cnt + CNT_W'(1);
                end else begin
                    psc_cnt <= psc_cnt + PSC_W'(1);
                end
            end

            if (ctrl_wr) begin
                ctrl <= ctrl_t'(wr_data[ONESHOT_BIT:EN_BIT]);
            end else if (match && ctrl.oneshot) begin
                ctrl.en <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/multi_timer.sv
// rtl/multi_timer.sv - multi-channel timer: address decode, sticky STATUS, registered read mux, IRQ merge
module multi_timer
    import timer_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32,
    parameter int PSC_W  = 16,
    parameter int ADDR_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDR_W-1:0]       address,
    input  logic                    wr_en,
    input  logic                    rd_en,
    input  logic [31:0]             wr_data,
    output logic [31:0]             rd_data,
    output logic                    rd_valid,
    output logic [NUM_CH*CNT_W-1:0] timer_cnt,
    output logic [NUM_CH-1:0]       ch_irq,
    output logic                    irq
);

    logic [7:0]       addr_lo;
    logic             addr_hi_zero;
    logic             status_hit;
    logic             ch_hit;
    logic [2:0]       ch_sel;
    logic [1:0]       reg_sel;

    ctrl_t            ctrl_arr [NUM_CH];
    logic [CNT_W-1:0] cnt_arr  [NUM_CH];
    logic [CNT_W-1:0] cmp_arr  [NUM_CH];
    logic [PSC_W-1:0] psc_arr  [NUM_CH];
    logic [NUM_CH-1:0] match_vec;
    logic [NUM_CH-1:0] ie_vec;
    logic [NUM_CH-1:0] status;
    logic [31:0]       rd_word;

    assign addr_lo      = address[7:0];
    assign addr_hi_zero = ((address >> 8) == '0);
    assign status_hit   = addr_hi_zero && (addr_lo[7:2] == STATUS_ADDR[7:2]);
    assign ch_sel       = ch_index(addr_lo);
    assign reg_sel      = reg_index(addr_lo);
    // Channel windows sit below STATUS_ADDR; windows beyond NUM_CH are unmapped.
    assign ch_hit       = addr_hi_zero && !addr_lo[7] && (int'(ch_sel) < NUM_CH);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        timer_channel #(
            .CNT_W (CNT_W),
            .PSC_W (PSC_W)
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .wr_en   (wr_en && ch_hit && (ch_sel == 3'(i))),
            .reg_sel (reg_sel),
            .wr_data (wr_data),
            .ctrl    (ctrl_arr[i]),
            .cnt     (cnt_arr[i]),
            .cmp     (cmp_arr[i]),
            .psc     (psc_arr[i]),
            .match   (match_vec[i])
        );

        assign timer_cnt[i*CNT_W +: CNT_W] = cnt_arr[i];
        assign ie_vec[i]                   = ctrl_arr[i].ie;
    end

    always_comb begin
        rd_word = '0;
        if (status_hit) begin
            rd_word[NUM_CH-1:0] = status;
        end else if (ch_hit) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch_sel == 3'(i)) begin
                    case (reg_sel)
                        SEL_CTRL: rd_word[ONESHOT_BIT:EN_BIT] = ctrl_arr[i];
                        SEL_CNT:  rd_word[CNT_W-1:0]          = cnt_arr[i];
                        SEL_CMP:  rd_word[CNT_W-1:0]          = cmp_arr[i];
                        default:  rd_word[PSC_W-1:0]          = psc_arr[i];
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status   <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            // A match event outranks a write-1-clear of the same bit.
            if (wr_en && status_hit) begin
                status <= (status & ~wr_data[NUM_CH-1:0]) | match_vec;
            end else begin
                status <= status | match_vec;
            end
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= rd_word;
            end
        end
    end

    assign ch_irq = status & ie_vec;
    assign irq    = |ch_irq;

endmodule

// File: tb/tb_multi_timer.sv
// tb/tb_multi_timer.sv - directed self-checking bench for multi_timer (4 channels, 8-bit counters)
module tb_multi_timer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  address = '0;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [31:0] wr_data = '0;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic [31:0] timer_cnt;
    logic [3:0]  ch_irq;
    logic        irq;

    int err_cnt = 0;
    int chk_cnt = 0;

    multi_timer #(
        .NUM_CH (4),
        .CNT_W  (8),
        .PSC_W  (16),
        .ADDR_W (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .address   (address),
        .wr_en     (wr_en),
        .rd_en     (rd_en),
        .wr_data   (wr_data),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .timer_cnt (timer_cnt),
        .ch_irq    (ch_irq),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] cnt_of(input int ch);
        return timer_cnt[ch*8 +: 8];
    endfunction

    // All bus tasks start at a falling edge; the access is sampled at the next rising edge.
    task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
        address = a;
        wr_data = d;
        wr_en   = 1'b1;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [7:0] a, input logic [31:0] exp);
        address = a;
        rd_en   = 1'b1;
        @(negedge clk);
        rd_en   = 1'b0;
        check({tag, ".valid"}, 32'(rd_valid), 32'd1);
        check(tag, rd_data, exp);
    endtask

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        check("rst.rd_valid", 32'(rd_valid), 32'd0);
        check("rst.rd_data", rd_data, 32'd0);
        check("rst.irq", 32'(irq), 32'd0);
        check("rst.timer_cnt", timer_cnt, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle.rd_valid", 32'(rd_valid), 32'd0);
        for (int ch = 0; ch < 4; ch++) begin
            for (int r = 0; r < 4; r++) begin
                read_check($sformatf("rst.reg%0d_%0d", ch, r), 8'(ch * 16 + r * 4), 32'd0);
            end
        end
        read_check("rst.status", 8'h80, 32'd0);
        read_check("unmapped.ch4", 8'h40, 32'd0);
        @(negedge clk);
        check("rd_valid.pulse", 32'(rd_valid), 32'd0);
        check("rst.irq2", 32'(irq), 32'd0);

        // channel 0: PSC=0, CMP=3, periodic, IE=1; enable at edge N
        bus_write(8'h08, 32'd3);
        bus_write(8'h00, 32'h3);
        check("c0.cnt.N", 32'(cnt_of(0)), 32'd0);
        repeat (3) @(negedge clk);
        check("c0.cnt.N3", 32'(cnt_of(0)), 32'd3);
        check("c0.irq.N3", 32'(irq), 32'd0);
        @(negedge clk);
        check("c0.irq.N4", 32'(irq), 32'd1);
        check("c0.cnt.N4", 32'(cnt_of(0)), 32'd0);
        bus_write(8'h80, 32'h1);
        check("c0.clr.irq", 32'(irq), 32'd0);
        repeat (2) @(negedge clk);
        check("c0.irq.N7", 32'(irq), 32'd0);
        @(negedge clk);
        check("c0.irq.N8", 32'(irq), 32'd1);
        repeat (3) @(negedge clk);
        bus_write(8'h80, 32'h1);
        check("c0.setwins.irq", 32'(irq), 32'd1);
        read_check("c0.setwins.status", 8'h80, 32'h1);
        bus_write(8'h80, 32'h1);
        check("c0.clr2.irq", 32'(irq), 32'd0);
        @(negedge clk);
        bus_write(8'h04, 32'd7);
        check("c0.cntwr.cnt", 32'(cnt_of(0)), 32'd7);
        check("c0.cntwr.irq", 32'(irq), 32'd0);
        bus_write(8'h00, 32'h0);
        repeat (2) @(negedge clk);
        check("c0.frozen", 32'(cnt_of(0)), 32'd8);

        // channel 1: PSC=2, CMP=1, one-shot, IE=1
        bus_write(8'h1C, 32'd2);
        bus_write(8'h18, 32'd1);
        bus_write(8'h10, 32'h7);
        repeat (5) @(negedge clk);
        check("c1.cnt.N5", 32'(cnt_of(1)), 32'd1);
        check("c1.irq.N5", 32'(irq), 32'd0);
        @(negedge clk);
        check("c1.irq.N6", 32'(irq), 32'd1);
        check("c1.cnt.N6", 32'(cnt_of(1)), 32'd0);
        read_check("c1.ctrl.en_off", 8'h10, 32'h6);
        repeat (12) @(negedge clk);
        check("c1.cnt.hold", 32'(cnt_of(1)), 32'd0);
        read_check("c1.status", 8'h80, 32'h2);
        bus_write(8'h80, 32'h2);
        repeat (8) @(negedge clk);
        check("c1.no_rematch", 32'(irq), 32'd0);

        // channel 2: width truncation, then CMP below CNT with 8-bit wrap
        bus_write(8'h24, 32'h1234);
        read_check("c2.cnt.trunc", 8'h24, 32'h34);
        bus_write(8'h2C, 32'h0001_0000);
        read_check("c2.psc.trunc", 8'h2C, 32'h0);
        bus_write(8'h24, 32'd10);
        bus_write(8'h28, 32'd5);
        bus_write(8'h20, 32'h3);
        repeat (245) @(negedge clk);
        check("c2.cnt.ff", 32'(cnt_of(2)), 32'd255);
        check("c2.irq.ff", 32'(irq), 32'd0);
        @(negedge clk);
        check("c2.cnt.wrap", 32'(cnt_of(2)), 32'd0);
        check("c2.irq.wrap", 32'(irq), 32'd0);
        repeat (5) @(negedge clk);
        check("c2.cnt.5", 32'(cnt_of(2)), 32'd5);
        check("c2.irq.5", 32'(irq), 32'd0);
        @(negedge clk);
        check("c2.irq.match", 32'(irq), 32'd1);
        check("c2.cnt.match", 32'(cnt_of(2)), 32'd0);
        bus_write(8'h80, 32'h4);
        check("c2.clr.irq", 32'(irq), 32'd0);
        repeat (4) @(negedge clk);
        check("c2.irq.p5", 32'(irq), 32'd0);
        @(negedge clk);
        check("c2.irq.p6", 32'(irq), 32'd1);
        bus_write(8'h20, 32'h0);
        bus_write(8'h80, 32'h4);
        check("c2.off.irq", 32'(irq), 32'd0);
        check("c0.still_frozen", 32'(cnt_of(0)), 32'd8);

        // channels 0 and 3 together, then CLR on channel 3
        bus_write(8'h04, 32'd0);
        bus_write(8'h08, 32'd2);
        bus_write(8'h38, 32'd4);
        bus_write(8'h30, 32'h3);
        bus_write(8'h00, 32'h3);
        repeat (3) @(negedge clk);
        check("c03.ch_irq.M4", 32'(ch_irq), 32'h1);
        @(negedge clk);
        check("c03.ch_irq.M5", 32'(ch_irq), 32'h9);
        bus_write(8'h00, 32'h0);
        bus_write(8'h80, 32'h1);
        check("c03.ch_irq.one", 32'(ch_irq), 32'h8);
        check("c03.irq.one", 32'(irq), 32'd1);
        bus_write(8'h80, 32'h8);
        check("c03.irq.both", 32'(irq), 32'd0);
        bus_write(8'h30, 32'hB);
        check("c03.clr.cnt3", 32'(cnt_of(3)), 32'd0);
        check("c03.clr.cnt0", 32'(cnt_of(0)), 32'd2);
        read_check("c03.ctrl3", 8'h30, 32'h3);
        repeat (3) @(negedge clk);
        check("c03.ch_irq.M13", 32'(ch_irq), 32'h0);
        @(negedge clk);
        check("c03.ch_irq.M14", 32'(ch_irq), 32'h8);

        // same-cycle read/write returns old value; back-to-back reads
        address = 8'h38;
        wr_data = 32'd9;
        wr_en   = 1'b1;
        rd_en   = 1'b1;
        @(negedge clk);
        wr_en   = 1'b0;
        check("rdwr.old", rd_data, 32'd4);
        address = 8'h08;
        @(negedge clk);
        check("b2b.valid0", 32'(rd_valid), 32'd1);
        check("b2b.cmp0", rd_data, 32'd2);
        address = 8'h38;
        @(negedge clk);
        rd_en   = 1'b0;
        check("b2b.valid1", 32'(rd_valid), 32'd1);
        check("b2b.cmp3", rd_data, 32'd9);

        // asynchronous reset mid-count
        #2 rst_n = 1'b0;
        #1;
        check("arst.timer_cnt", timer_cnt, 32'd0);
        check("arst.irq", 32'(irq), 32'd0);
        check("arst.rd_valid", 32'(rd_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("arst.no_count", timer_cnt, 32'd0);
        read_check("arst.ctrl3", 8'h30, 32'h0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
